// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and defaults for bit-serial arithmetic blocks
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational subtractor cell (x - y - bi)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    // Borrow when y exceeds x, or when they are equal and a borrow arrives.
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor, one bit per clock
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bo_bit;
  logic             last_bit;

  full_subtractor u_cell (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands shift right so the cell always sees the current bit at index 0;
  // the result fills from the MSB side and lands aligned after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            br    <= bin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          br    <= bo_bit;
          diff  <= {d_bit, diff[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            bout <= bo_bit;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor against an arithmetic model
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase counts edges since acceptance; the result is plain integer subtraction.
  int           phase;
  logic [W-1:0] p_diff;
  logic         p_bout;
  logic [W-1:0] m_diff;
  logic         m_bout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 0;
      m_diff <= '0;
      m_bout <= 1'b0;
      p_diff <= '0;
      p_bout <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase  <= 1;
        p_diff <= W'(int'(a) - int'(b) - int'(bin));
        p_bout <= (int'(a) < int'(b) + int'(bin));
      end
    end else if (phase == W) begin
      phase  <= W + 1;
      m_diff <= p_diff;
      m_bout <= p_bout;
    end else if (phase == W + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, (phase >= 1 && phase <= W));
    chk("done", done, (phase == W + 1));
    if (phase == 0 || phase == W + 1) begin
      chk("diff", diff, m_diff);
      chk("bout", bout, m_bout);
    end
  end

  // Done spacing while start is held high.
  logic rand_phase = 1'b0;
  int   cyc        = 0;
  int   last_done  = -1;
  int   rand_dones = 0;

  always @(negedge clk) begin
    cyc++;
    if (rand_phase && done) begin
      if (last_done >= 0) chk("spacing", cyc - last_done, W + 2);
      last_done = cyc;
      rand_dones++;
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_directed(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                              input logic [W-1:0] ed, input logic eb, input bit mid_pulse,
                              input string name);
    int edges;
    int dc;
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    while (done !== 1'b1 && edges < 40) begin
      if (mid_pulse) start = (edges == 4);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " latency"}, edges, 9);
    chk({name, " diff"}, diff, ed);
    chk({name, " bout"}, bout, eb);
    if (mid_pulse) begin
      dc = 0;
      repeat (2 * W) begin
        @(negedge clk);
        if (done) dc++;
      end
      chk({name, " extra done"}, dc, 0);
      chk({name, " diff held"}, diff, ed);
      chk({name, " bout held"}, bout, eb);
    end
  endtask

  initial begin
    int dc;
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_directed(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, "5A-23");
    @(negedge clk);
    run_directed(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, "10-20");
    @(negedge clk);
    run_directed(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "00-00-1");
    @(negedge clk);
    run_directed(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, "FF-FF");

    // Abort in the middle of RUN.
    @(negedge clk);
    a     = 8'h77;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort no done", dc, 0);
    chk("abort diff after", diff, 0);
    run_directed(8'h77, 8'h11, 1'b0, 8'h66, 1'b0, 1'b0, "77-11");
    @(negedge clk);

    // Back-to-back random operations with start held high; inputs churn every cycle.
    rand_phase = 1'b1;
    start      = 1'b1;
    guard      = 0;
    while (rand_dones < 5000 && guard < 60000) begin
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    start      = 1'b0;
    rand_phase = 1'b0;
    chk("random done count", rand_dones, 5000);
    repeat (2 * W + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled with start.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port diff, output, WIDTH bits: result a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out, high when a < b + bin (unsigned).

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL on that edge latch a, b and bin into internal registers, clear the bit counter, and enter RUN.
REQ-014 In RUN, the block SHALL process one bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-015 Per bit, the block SHALL compute d = a_i ^ b_i ^ br.
REQ-016 Per bit, the block SHALL compute br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 Per bit, the block SHALL shift d into diff from the MSB side (diff shifts right).
REQ-018 After the WIDTH-th RUN edge, the block SHALL enter DONE with diff holding the full result and bout holding the final borrow.
REQ-019 The block SHALL assert busy only in RUN.
REQ-020 The block SHALL assert done only in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally.
REQ-021 Latency SHALL be fixed: done is high in the cycle after the (WIDTH+1)-th rising edge counted from the edge that sampled start, i.e. WIDTH RUN edges plus the load edge.
REQ-022 diff and bout SHALL be held stable from DONE until the next accepted start.
REQ-023 start SHALL be ignored in RUN and in DONE; a, b and bin changing during RUN SHALL NOT affect the result.
REQ-024 start held high continuously SHALL produce back-to-back operations, each re-sampled in IDLE, with a minimum of WIDTH+2 cycles between successive done pulses.
REQ-025 Wrap-around SHALL be supported: underflow yields the two's-complement modulo result with bout=1, with no saturation.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, borrow register=0 and counter=0, regardless of clock.
REQ-027 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and no partial result visible after release.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package serial_arith_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant; it is reused by a future serial adder.
REQ-030 One sub-module, full_subtractor (inputs x, y, bi; outputs d, bo), SHALL implement the per-bit cell combinationally and be instantiated once.
REQ-031 The counter SHALL be $clog2(WIDTH+1) bits wide; all other state SHALL be explicit flops in the top module.

Verification (WIDTH=8)
REQ-032 a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0; done exactly 9 edges after the start edge.
REQ-033 a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0; start pulsed again during RUN -> no second done, result unchanged.
REQ-035 rst_n low at RUN cycle 4 -> outputs zero immediately, no done; a new start after release yields the correct result.
REQ-036 5000 random (a, b, bin) with start held high -> every done matches (a - b - bin) mod 256 and the borrow, with done spacing of 10 cycles.
